// File: rtl/scan_chain_selftest.sv
// On-chip pulse launcher and checker for the fabric scan chain: flushes the chain, fires
// periodic single-bit pulses into sc_head and compares sc_tail against a delay-line model.
module scan_chain_selftest #(
    parameter int CHAIN_LEN  = 80,
    parameter int PERIOD     = 20,
    parameter int NUM_PULSES = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    output logic             sc_head,
    input  logic             sc_tail,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam int CW = (CHAIN_LEN  > 1) ? $clog2(CHAIN_LEN)  : 1;
    localparam int PW = (PERIOD     > 1) ? $clog2(PERIOD)     : 1;
    localparam int NW = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1;

    typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [PW-1:0]          phase_reg, phase_next;
    logic [NW-1:0]          pulse_reg, pulse_next;
    logic                   sc_head_reg;
    logic [ERR_W-1:0]       err_reg;
    logic [CHAIN_LEN-1:0]   model_reg;
    logic [1:0]             rst_pipe_reg;
    logic                   rst_n;
    logic                   launch;
    logic                   mismatch;

    // Reset asserts immediately but releases two edges after Reset_n rises.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_pipe_reg <= 2'b00;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
        end
    end
    assign rst_n = rst_pipe_reg[1];

    assign launch = ((state_reg == IDLE) || (state_reg == DONE)) && start;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        pulse_next = pulse_reg;
        unique case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                    phase_next = '0;
                    pulse_next = '0;
                end
            end
            FLUSH: begin
                if (cnt_reg == CW'(CHAIN_LEN - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (phase_reg == PW'(PERIOD - 1)) begin
                    phase_next = '0;
                    if (pulse_reg == NW'(NUM_PULSES - 1)) begin
                        state_next = DRAIN;
                        pulse_next = '0;
                    end else begin
                        pulse_next = pulse_reg + 1'b1;
                    end
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_reg == CW'(CHAIN_LEN - 1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            phase_reg   <= '0;
            pulse_reg   <= '0;
            sc_head_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            phase_reg   <= phase_next;
            pulse_reg   <= pulse_next;
            // Decided from next-cycle values so the flop output itself marks the pulse cycle.
            sc_head_reg <= (state_next == RUN) && (phase_next == PW'(PERIOD - 1));
        end
    end

    // Delay line: model_reg[i] holds sc_head from i+1 cycles ago.
    genvar gi;
    generate
        for (gi = 0; gi < CHAIN_LEN; gi++) begin : g_model
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    model_reg[gi] <= 1'b0;
                end else if (launch) begin
                    model_reg[gi] <= 1'b0;
                end else begin
                    if (gi == 0) begin
                        model_reg[gi] <= sc_head_reg;
                    end else begin
                        model_reg[gi] <= model_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    assign mismatch = ((state_reg == RUN) || (state_reg == DRAIN)) &&
                      (sc_tail != model_reg[CHAIN_LEN-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= '0;
        end else if (launch) begin
            err_reg <= '0;
        end else if (mismatch && (err_reg != {ERR_W{1'b1}})) begin
            err_reg <= err_reg + 1'b1;
        end
    end

    assign sc_head   = sc_head_reg;
    assign busy      = (state_reg == FLUSH) || (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign pass      = done && (err_reg == '0);
    assign err_count = err_reg;

endmodule

// File: tb/tb_scan_chain_selftest.sv
// Randomized bench for scan_chain_selftest: a bench-side chain model drives sc_tail and a
// cycle-indexed reference predicts every output on each falling edge.
module tb_scan_chain_selftest;

    localparam int L   = 80;
    localparam int P   = 20;
    localparam int N   = 4;
    localparam int EW  = 16;
    localparam int TOT = 2 * L + N * P;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          start = 1'b0;
    logic          start4 = 1'b0;
    logic          sc_head, sc_tail, busy, done, pass;
    logic [EW-1:0] err_count;
    logic          sc_head4, busy4, done4, pass4;
    logic [3:0]    err4;

    int total = 0;
    int bad   = 0;

    // Bench-side scan chain: mode 0 = loopback, 1 = stuck at 1, 2 = loopback with random flips
    int          mode = 0;
    int          chain_len = L;
    logic [127:0] chain = '0;
    logic        flip = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        chain <= {chain[126:0], sc_head};
        flip  <= ($urandom_range(7) == 0);
    end

    assign sc_tail = (mode == 1) ? 1'b1 : (chain[chain_len-1] ^ ((mode == 2) ? flip : 1'b0));

    scan_chain_selftest #(.CHAIN_LEN(L), .PERIOD(P), .NUM_PULSES(N), .ERR_W(EW)) dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .sc_head(sc_head), .sc_tail(sc_tail),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    scan_chain_selftest #(.CHAIN_LEN(L), .PERIOD(P), .NUM_PULSES(N), .ERR_W(4)) dut4 (
        .clk(clk), .Reset_n(Reset_n), .start(start4), .sc_head(sc_head4), .sc_tail(1'b1),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err4)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: t counts cycles since the start edge (1 = first flush cycle).
    function automatic int head_at(input int t);
        int r;
        r = t - 1 - L;
        return ((r >= 0) && (r < N * P) && ((r % P) == P - 1)) ? 1 : 0;
    endfunction

    int m_t = 0;
    int m_active = 0;
    int m_done = 0;
    int m_err = 0;

    always @(negedge clk) begin
        if (!Reset_n) begin
            m_active = 0;
            m_done   = 0;
            m_err    = 0;
            m_t      = 0;
        end
        check("busy", int'(busy), m_active);
        check("done", int'(done), m_done);
        check("pass", int'(pass), (m_done != 0 && m_err == 0) ? 1 : 0);
        check("err_count", int'(err_count), m_err);
        check("sc_head", int'(sc_head), (m_active != 0) ? head_at(m_t) : 0);
        if (Reset_n) begin
            if (m_active != 0) begin
                if (m_t > L && int'(sc_tail) != head_at(m_t - L) && m_err < (1 << EW) - 1)
                    m_err++;
                if (m_t == TOT) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_t++;
                end
            end else if (start) begin
                m_active = 1;
                m_done   = 0;
                m_t      = 1;
                m_err    = 0;
            end
        end
    end

    int pulse_q[$];

    // Pulse start, then count falling edges until done; records RUN indices of sc_head pulses.
    task automatic run_test(input int md, input int len, input bit with4, output int cyc);
        mode = md;
        chain_len = len;
        pulse_q.delete();
        @(posedge clk); #1;
        start = 1'b1;
        start4 = with4;
        @(posedge clk); #1;
        start = 1'b0;
        start4 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (sc_head) pulse_q.push_back(cyc - 1 - L);
        end while (!done && cyc < 400);
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        int done_cycles;
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        check("rst_head", int'(sc_head), 0);
        Reset_n = 1'b1;
        repeat (4) @(posedge clk);

        run_test(0, L, 1'b1, cyc);
        $display("loopback: cycles=%0d err=%0d pass=%0d", cyc, err_count, pass);
        check("loop_cycles", cyc, TOT + 1);
        check("loop_err", int'(err_count), 0);
        check("loop_pass", int'(pass), 1);
        check("loop_npulses", pulse_q.size(), 4);
        for (int i = 0; i < pulse_q.size() && i < 4; i++)
            check("loop_pulse_pos", pulse_q[i], 19 + 20 * i);
        $display("err_w4 stuck1: done=%0d err=%0d pass=%0d", done4, err4, pass4);
        check("w4_done", int'(done4), 1);
        check("w4_err_sat", int'(err4), 15);
        check("w4_pass", int'(pass4), 0);

        run_test(1, L, 1'b0, cyc);
        $display("stuck1: err=%0d pass=%0d", err_count, pass);
        check("stuck_err", int'(err_count), 156);
        check("stuck_pass", int'(pass), 0);

        run_test(0, L + 1, 1'b0, cyc);
        $display("chain81: err=%0d pass=%0d", err_count, pass);
        check("off1_err", int'(err_count), 7);
        check("off1_pass", int'(pass), 0);

        for (int k = 0; k < 3; k++) begin
            run_test(2, L, 1'b0, cyc);
            $display("random flips %0d: err=%0d model=%0d", k, err_count, m_err);
        end

        // Start held high: one DONE cycle, then an automatic restart.
        mode = 0;
        chain_len = L;
        @(posedge clk); #1;
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
        done_cycles = 0;
        while (done && done_cycles < 10) begin
            done_cycles++;
            @(negedge clk);
        end
        $display("start held: done_cycles=%0d busy=%0d err=%0d", done_cycles, busy, err_count);
        check("held_done_cycles", done_cycles, 1);
        check("held_restart_busy", int'(busy), 1);
        check("held_restart_err", int'(err_count), 0);
        #1 start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
        check("held_second_pass", int'(pass), 1);

        // Reset mid-RUN with errors already counted.
        mode = 1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (120) @(negedge clk);
        check("pre_rst_err_nonzero", (err_count != 0) ? 1 : 0, 1);
        @(posedge clk); #3;
        Reset_n = 1'b0;
        #1;
        $display("mid-run reset: busy=%0d done=%0d err=%0d head=%0d", busy, done, err_count, sc_head);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_pass", int'(pass), 0);
        check("midrst_err", int'(err_count), 0);
        check("midrst_head", int'(sc_head), 0);
        repeat (2) @(posedge clk);
        #1 Reset_n = 1'b1;
        repeat (4) @(posedge clk);
        run_test(0, L, 1'b0, cyc);
        $display("post-reset loopback: err=%0d pass=%0d", err_count, pass);
        check("post_rst_pass", int'(pass), 1);
        check("post_rst_cycles", cyc, TOT + 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
